// File: rtl/tlast_ptr_store_multi_pkg.sv
// Shared definitions for the per-line end-of-frame pointer store and the
// write/read logic that drives it: default geometry and {line,char} helpers.
package tlast_ptr_store_multi_pkg;

    localparam int LINE_AW_DEF = 2;
    localparam int CHAR_AW_DEF = 11;
    localparam int NL          = 2 ** LINE_AW_DEF;
    localparam int PW          = LINE_AW_DEF + CHAR_AW_DEF;

    typedef struct packed {
        logic ovw;
        logic unf;
    } err_flags_t;

    // A buffer pointer is {line, char}; the char field occupies the low char_aw bits.
    function automatic int unsigned line_of(input int unsigned ptr, input int unsigned char_aw);
        return ptr >> char_aw;
    endfunction

    function automatic int unsigned char_of(input int unsigned ptr, input int unsigned char_aw);
        return ptr & ((32'd1 << char_aw) - 32'd1);
    endfunction

endpackage

// File: rtl/tlast_ptr_store_multi_if.sv
// Commit/read/release bus between the packet-buffer write and read logic and
// the tlast pointer store.
interface tlast_ptr_store_multi_if
    import tlast_ptr_store_multi_pkg::*;
#(
    parameter int LINE_AW = LINE_AW_DEF,
    parameter int CHAR_AW = CHAR_AW_DEF
);

    localparam int PTR_W = LINE_AW + CHAR_AW;

    logic [PTR_W-1:0]   wr_ptr;
    logic               wr_commit;
    logic [PTR_W-1:0]   rd_ptr;
    logic               rd_release;

    logic               tlast_flag;
    logic               rd_valid;
    logic [CHAR_AW:0]   rd_len;
    logic [LINE_AW:0]   line_cnt;
    logic               full;
    logic               empty;
    logic               err_ovw;
    logic               err_unf;

    // master: the write/read logic; slave: the pointer store
    modport master (
        output wr_ptr, wr_commit, rd_ptr, rd_release,
        input  tlast_flag, rd_valid, rd_len, line_cnt, full, empty, err_ovw, err_unf
    );

    modport slave (
        input  wr_ptr, wr_commit, rd_ptr, rd_release,
        output tlast_flag, rd_valid, rd_len, line_cnt, full, empty, err_ovw, err_unf
    );

endinterface

// File: rtl/tlast_ptr_store_multi_ram.sv
// Small dual-port RAM: synchronous write, asynchronous (combinational) read.
// No reset; contents are only meaningful where the owner tracks them valid.
module dual_port_asyncout_ram #(
    parameter int D_WIDTH = 11,
    parameter int A_WIDTH = 2
) (
    input  logic               clk,
    input  logic               we,
    input  logic [A_WIDTH-1:0] waddr,
    input  logic [D_WIDTH-1:0] wdata,
    input  logic [A_WIDTH-1:0] raddr,
    output logic [D_WIDTH-1:0] rdata
);

    logic [D_WIDTH-1:0] mem [2**A_WIDTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/tlast_ptr_store_multi.sv
// Per-line end-of-frame pointer store: one committed last-char pointer per
// buffer line, with valid bits, occupancy count, sticky errors and optional output register.
module tlast_ptr_store_multi
    import tlast_ptr_store_multi_pkg::*;
#(
    parameter int LINE_AW = LINE_AW_DEF,
    parameter int CHAR_AW = CHAR_AW_DEF,
    parameter int REG_OUT = 0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    tlast_ptr_store_multi_if.slave  bus
);

    localparam int NUM_LINES = 2 ** LINE_AW;

    logic [LINE_AW-1:0]   wr_line;
    logic [CHAR_AW-1:0]   wr_char;
    logic [LINE_AW-1:0]   rd_line;
    logic [CHAR_AW-1:0]   rd_char;

    logic [NUM_LINES-1:0] valid_q;
    logic [NUM_LINES-1:0] valid_d;
    logic [LINE_AW:0]     cnt_q;
    logic [LINE_AW:0]     cnt_d;
    err_flags_t           err_q;
    err_flags_t           err_d;

    logic                 rel_hit;
    logic                 rel_ok;
    logic                 commit_ok;

    logic [CHAR_AW-1:0]   ram_rdata;
    logic                 rd_valid_c;
    logic                 tlast_c;
    logic [CHAR_AW:0]     rd_len_c;

    assign wr_line = LINE_AW'(line_of(32'(bus.wr_ptr), CHAR_AW));
    assign wr_char = CHAR_AW'(char_of(32'(bus.wr_ptr), CHAR_AW));
    assign rd_line = LINE_AW'(line_of(32'(bus.rd_ptr), CHAR_AW));
    assign rd_char = CHAR_AW'(char_of(32'(bus.rd_ptr), CHAR_AW));

    // Release is applied before commit, so a same-line release+commit frees
    // the line and immediately refills it without flagging an overwrite.
    always_comb begin
        rel_hit   = valid_q[rd_line];
        rel_ok    = bus.rd_release && rel_hit;
        commit_ok = bus.wr_commit &&
                    (!valid_q[wr_line] || (rel_ok && (wr_line == rd_line)));

        valid_d = valid_q;
        if (rel_ok) begin
            valid_d[rd_line] = 1'b0;
        end
        if (commit_ok) begin
            valid_d[wr_line] = 1'b1;
        end

        cnt_d = cnt_q;
        case ({commit_ok, rel_ok})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase

        err_d = err_q;
        if (bus.wr_commit && !commit_ok) begin
            err_d.ovw = 1'b1;
        end
        if (bus.rd_release && !rel_hit) begin
            err_d.unf = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            cnt_q   <= '0;
            err_q   <= '0;
        end else begin
            valid_q <= valid_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    dual_port_asyncout_ram #(
        .D_WIDTH (CHAR_AW),
        .A_WIDTH (LINE_AW)
    ) u_ptr_ram (
        .clk   (clk),
        .we    (commit_ok),
        .waddr (wr_line),
        .wdata (wr_char),
        .raddr (rd_line),
        .rdata (ram_rdata)
    );

    // Stale pointers of released lines stay in the RAM; valid masks them here.
    always_comb begin
        rd_valid_c = valid_q[rd_line];
        tlast_c    = rd_valid_c && (ram_rdata == rd_char);
        rd_len_c   = rd_valid_c ? ({1'b0, ram_rdata} + 1'b1) : '0;
    end

    generate
        if (REG_OUT != 0) begin : g_reg_out
            logic             tlast_q;
            logic             rd_valid_q;
            logic [CHAR_AW:0] rd_len_q;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    tlast_q    <= 1'b0;
                    rd_valid_q <= 1'b0;
                    rd_len_q   <= '0;
                end else begin
                    tlast_q    <= tlast_c;
                    rd_valid_q <= rd_valid_c;
                    rd_len_q   <= rd_len_c;
                end
            end

            assign bus.tlast_flag = tlast_q;
            assign bus.rd_valid   = rd_valid_q;
            assign bus.rd_len     = rd_len_q;
        end else begin : g_comb_out
            assign bus.tlast_flag = tlast_c;
            assign bus.rd_valid   = rd_valid_c;
            assign bus.rd_len     = rd_len_c;
        end
    endgenerate

    assign bus.line_cnt = cnt_q;
    assign bus.full     = (cnt_q == (LINE_AW+1)'(NUM_LINES));
    assign bus.empty    = (cnt_q == '0);
    assign bus.err_ovw  = err_q.ovw;
    assign bus.err_unf  = err_q.unf;

endmodule

// File: tb/tb_tlast_ptr_store_multi.sv
// Scoreboard bench for tlast_ptr_store_multi: one combinational-output and one
// registered-output instance share stimulus and are checked against a frame-level model.
module tb_tlast_ptr_store_multi;
    import tlast_ptr_store_multi_pkg::*;

    localparam int LA    = LINE_AW_DEF;
    localparam int CA    = CHAR_AW_DEF;
    localparam int LINES = NL;
    localparam int CMAX  = (1 << CA) - 1;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          wr_commit;
    logic          rd_release;

    tlast_ptr_store_multi_if #(.LINE_AW(LA), .CHAR_AW(CA)) bus0 ();
    tlast_ptr_store_multi_if #(.LINE_AW(LA), .CHAR_AW(CA)) bus1 ();

    assign bus0.wr_ptr     = wr_ptr;
    assign bus0.wr_commit  = wr_commit;
    assign bus0.rd_ptr     = rd_ptr;
    assign bus0.rd_release = rd_release;
    assign bus1.wr_ptr     = wr_ptr;
    assign bus1.wr_commit  = wr_commit;
    assign bus1.rd_ptr     = rd_ptr;
    assign bus1.rd_release = rd_release;

    tlast_ptr_store_multi #(.LINE_AW(LA), .CHAR_AW(CA), .REG_OUT(0)) dut_comb (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus0)
    );

    tlast_ptr_store_multi #(.LINE_AW(LA), .CHAR_AW(CA), .REG_OUT(1)) dut_reg (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus1)
    );

    typedef struct packed {
        bit tlast;
        bit rvalid;
        int len;
        int cnt;
        bit full;
        bit empty;
        bit ovw;
        bit unf;
    } exp_t;

    exp_t exp_q[$];
    exp_t prev_exp;

    bit mvalid [LINES];
    int mptr   [LINES];
    bit movw;
    bit munf;

    int checks = 0;
    int errors = 0;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("[TB] FAIL %s actual=%0d expected=%0d at %0t", name, act, expv, $time);
        end
    endtask

    task automatic modelReset();
        for (int i = 0; i < LINES; i++) begin
            mvalid[i] = 1'b0;
            mptr[i]   = 0;
        end
        movw     = 1'b0;
        munf     = 1'b0;
        prev_exp = '0;
    endtask

    function automatic exp_t modelOutputs(input int rl, input int rc);
        exp_t e;
        int   n;
        n = 0;
        for (int i = 0; i < LINES; i++) begin
            if (mvalid[i]) n++;
        end
        e.rvalid = mvalid[rl];
        e.tlast  = mvalid[rl] && (mptr[rl] == rc);
        e.len    = mvalid[rl] ? mptr[rl] + 1 : 0;
        e.cnt    = n;
        e.full   = (n == LINES);
        e.empty  = (n == 0);
        e.ovw    = movw;
        e.unf    = munf;
        return e;
    endfunction

    // Drive one cycle, queue the outputs this cycle must show, then advance the model.
    task automatic applyStimulus(input bit c, input int wl, input int wc,
                                 input bit r, input int rl, input int rc);
        @(posedge clk);
        #1;
        wr_commit  = c;
        wr_ptr     = PW'((wl << CA) | wc);
        rd_release = r;
        rd_ptr     = PW'((rl << CA) | rc);
        exp_q.push_back(modelOutputs(rl, rc));
        if (r) begin
            if (mvalid[rl]) mvalid[rl] = 1'b0;
            else            munf = 1'b1;
        end
        if (c) begin
            if (mvalid[wl]) begin
                movw = 1'b1;
            end else begin
                mvalid[wl] = 1'b1;
                mptr[wl]   = wc;
            end
        end
    endtask

    task automatic drainQueue();
        for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(negedge clk);
        #1;
        checkOutput("drain_queue_empty", exp_q.size(), 0);
    endtask

    // Monitor: the registered instance shows last cycle's read-side outputs.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checkOutput("c_tlast",    bus0.tlast_flag, e.tlast);
                checkOutput("c_rd_valid", bus0.rd_valid,   e.rvalid);
                checkOutput("c_rd_len",   bus0.rd_len,     e.len);
                checkOutput("c_line_cnt", bus0.line_cnt,   e.cnt);
                checkOutput("c_full",     bus0.full,       e.full);
                checkOutput("c_empty",    bus0.empty,      e.empty);
                checkOutput("c_err_ovw",  bus0.err_ovw,    e.ovw);
                checkOutput("c_err_unf",  bus0.err_unf,    e.unf);
                checkOutput("r_tlast",    bus1.tlast_flag, prev_exp.tlast);
                checkOutput("r_rd_valid", bus1.rd_valid,   prev_exp.rvalid);
                checkOutput("r_rd_len",   bus1.rd_len,     prev_exp.len);
                checkOutput("r_line_cnt", bus1.line_cnt,   e.cnt);
                checkOutput("r_err_ovw",  bus1.err_ovw,    e.ovw);
                checkOutput("r_err_unf",  bus1.err_unf,    e.unf);
                prev_exp = e;
            end
        end
    end

    initial begin
        int wl, wc, rl, rc;
        bit c, r;

        wr_commit  = 1'b0;
        rd_release = 1'b0;
        wr_ptr     = '0;
        rd_ptr     = '0;
        modelReset();

        #2;
        checkOutput("rst_empty",    bus0.empty,      1);
        checkOutput("rst_full",     bus0.full,       0);
        checkOutput("rst_line_cnt", bus0.line_cnt,   0);
        checkOutput("rst_r_tlast",  bus1.tlast_flag, 0);
        checkOutput("rst_r_len",    bus1.rd_len,     0);
        checkOutput("rst_err_ovw",  bus0.err_ovw,    0);
        #20;
        @(negedge clk);
        #2;
        rst_n = 1'b1;

        applyStimulus(0, 0, 0,    0, 0, 0);
        applyStimulus(1, 1, 37,   0, 1, 36);
        applyStimulus(0, 0, 0,    0, 1, 36);
        applyStimulus(0, 0, 0,    0, 1, 37);
        applyStimulus(1, 0, 100,  0, 1, 37);
        applyStimulus(1, 2, 500,  0, 2, 500);
        applyStimulus(1, 3, 5,    0, 3, 5);
        applyStimulus(0, 0, 0,    0, 3, 5);
        applyStimulus(1, 3, 9,    1, 3, 5);
        applyStimulus(0, 0, 0,    0, 3, 9);
        applyStimulus(0, 0, 0,    0, 3, 5);
        applyStimulus(1, 2, 77,   0, 2, 500);
        applyStimulus(0, 0, 0,    0, 2, 500);
        applyStimulus(0, 0, 0,    1, 0, 0);
        applyStimulus(0, 0, 0,    1, 0, 0);
        applyStimulus(1, 0, CMAX, 1, 1, 37);
        applyStimulus(0, 0, 0,    0, 0, CMAX);
        applyStimulus(0, 0, 0,    0, 0, CMAX - 1);
        applyStimulus(0, 0, 0,    0, 0, CMAX);
        drainQueue();

        // Async reset mid-frame with three lines valid, no clock edge in between.
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("arst_c_line_cnt", bus0.line_cnt,   0);
        checkOutput("arst_c_empty",    bus0.empty,      1);
        checkOutput("arst_c_rd_valid", bus0.rd_valid,   0);
        checkOutput("arst_c_tlast",    bus0.tlast_flag, 0);
        checkOutput("arst_c_rd_len",   bus0.rd_len,     0);
        checkOutput("arst_c_err_ovw",  bus0.err_ovw,    0);
        checkOutput("arst_c_err_unf",  bus0.err_unf,    0);
        checkOutput("arst_r_rd_valid", bus1.rd_valid,   0);
        checkOutput("arst_r_tlast",    bus1.tlast_flag, 0);
        checkOutput("arst_r_rd_len",   bus1.rd_len,     0);
        checkOutput("arst_r_line_cnt", bus1.line_cnt,   0);
        modelReset();
        @(negedge clk);
        #2;
        rst_n = 1'b1;

        for (int n = 0; n < 400; n++) begin
            c  = ($urandom_range(0, 9) < 4);
            wl = $urandom_range(0, LINES - 1);
            wc = ($urandom_range(0, 3) == 0) ? CMAX : $urandom_range(0, CMAX);
            r  = ($urandom_range(0, 9) < 3);
            rl = $urandom_range(0, LINES - 1);
            rc = ($urandom_range(0, 1) == 1) ? mptr[rl] : $urandom_range(0, CMAX);
            applyStimulus(c, wl, wc, r, rl, rc);
        end
        applyStimulus(0, 0, 0, 0, 0, 0);
        drainQueue();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
